// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared MEM/WB types and default widths
package pipe_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              wr;
    } wb_entry_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - 2-entry in-order skid FIFO for write-back entries
module wb_skid_fifo
    import pipe_pkg::*;
#(
    parameter type T = wb_entry_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  T           din,
    input  logic       pop,
    output T           head,
    output logic [1:0] count
);
    T     slot0;
    T     slot1;
    logic push_ok;
    logic pop_ok;

    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = slot0;

    // slot0 is always the head; slot1 only holds the second entry
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // only reachable with count == 1: head leaves, new entry takes its place
                    slot0 <= din;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - MEM/WB write-back stage with skid buffer, forwarding tap and retire counter
module write_back_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W      = pipe_pkg::DATA_W,
    parameter int ADDR_W      = pipe_pkg::ADDR_W,
    parameter int CNT_W       = 16,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              wr;
    } entry_t;

    entry_t           din;
    entry_t           head;
    logic [1:0]       count;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] retired;

    assign din.data = in_mem_to_reg ? in_mem_data : in_alu_res;
    assign din.rd   = in_rd;
    assign din.wr   = in_reg_write && !(ZERO_REG_EN && (in_rd == ADDR_W'(ZERO_REG)));

    assign in_ready   = (count != 2'd2) && !reset;
    assign head_valid = (count != 2'd0) && !reset;
    assign push       = in_valid && in_ready && !flush;
    assign pop        = head_valid && rf_ready && !flush;

    wb_skid_fifo #(.T(entry_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign rf_we    = head_valid && head.wr;
    assign rf_waddr = reset ? '0 : head.rd;
    assign rf_wdata = reset ? '0 : head.data;

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

    // non-writing entries still retire and count; wraps freely
    always_ff @(posedge clk) begin
        if (reset)    retired <= '0;
        else if (pop) retired <= retired + CNT_W'(1);
    end

    assign retire_count = reset ? '0 : retired;
endmodule
